// File: rtl/bank_port_a_arbiter.sv
// bank_port_a_arbiter
//   Round-robin arbiter/sequencer for the shared port A of the four-bank RAM
//   (4-bit address: [3:2] bank, [1:0] word). One read or write is in flight
//   at a time. Each requester gets a one-cycle accept pulse, and read data is
//   returned to the owning requester through a registered response.
//
// Ports
//   clk, rst_n      clock; synchronous active-low reset
//   req_valid       per-requester request
//   req_we          per-requester write enable (1 = write, 0 = read)
//   req_addr        requester i address in bits [4i+3:4i]
//   req_wdata       requester i write data in bits [DATA*i +: DATA]
//   req_ready       one-hot, one-cycle accept pulse
//   rsp_valid       one-hot, one-cycle read-data-valid pulse
//   rsp_rdata       read data, meaningful while rsp_valid != 0
//   busy            high whenever the sequencer is not idle
//   ram_a_*         RAM port A write enable, address, write data, read data
module bank_port_a_arbiter #(
    parameter int DATA   = 256,
    parameter int NREQ   = 3,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*4-1:0]    req_addr,
    input  logic [NREQ*DATA-1:0] req_wdata,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [DATA-1:0]      rsp_rdata,
    output logic                 busy,
    output logic                 ram_a_w,
    output logic [3:0]           ram_a_adbus,
    output logic [DATA-1:0]      ram_a_data_in,
    input  logic [DATA-1:0]      ram_a_data_out
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     owner_q;
    logic [PW-1:0]     winner;
    logic              found;
    logic              we_q;
    logic [3:0]        addr_q;
    logic [DATA-1:0]   wdata_q;
    logic [DATA-1:0]   rdata_q;
    logic [CW-1:0]     cnt_q;

    // Cyclic priority search starting at ptr_q: first look at indices
    // >= ptr_q; if none is valid, the lowest valid index (necessarily below
    // ptr_q) wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req_valid[i] && (PW'(i) >= ptr_q)) begin
                winner = PW'(i);
                found  = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req_valid[i]) begin
                winner = PW'(i);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        rsp_valid = '0;
        case (state_q)
            IDLE: begin
                // Accept is suppressed while reset is asserted so nothing
                // is handshaken that the sequencer will not carry out.
                if (found && rst_n) begin
                    req_ready[winner] = 1'b1;
                    state_d           = ISSUE;
                end
            end
            ISSUE:   state_d = we_q ? IDLE : WAIT;
            WAIT:    if (cnt_q == '0) state_d = RESP;
            RESP: begin
                rsp_valid[owner_q] = 1'b1;
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (found) begin
                        owner_q <= winner;
                        we_q    <= req_we[winner];
                        addr_q  <= req_addr[winner*4 +: 4];
                        wdata_q <= req_wdata[winner*DATA +: DATA];
                        ptr_q   <= (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;
                    end
                end
                ISSUE: begin
                    if (!we_q) cnt_q <= CW'(RD_LAT - 1);
                end
                WAIT: begin
                    if (cnt_q == '0) rdata_q <= ram_a_data_out;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // The address register is only reloaded on acceptance, so the port
    // address naturally holds its last value outside ISSUE/WAIT.
    assign ram_a_adbus   = addr_q;
    assign ram_a_w       = (state_q == ISSUE) && we_q;
    assign ram_a_data_in = (state_q == ISSUE) ? wdata_q : '0;
    assign rsp_rdata     = rdata_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_bank_port_a_arbiter.sv
module tb_bank_port_a_arbiter;

    localparam int DATA   = 256;
    localparam int NREQ   = 3;
    localparam int RD_LAT = 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_we;
    logic [NREQ*4-1:0]    req_addr;
    logic [NREQ*DATA-1:0] req_wdata;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      rsp_valid;
    logic [DATA-1:0]      rsp_rdata;
    logic                 busy;
    logic                 ram_a_w;
    logic [3:0]           ram_a_adbus;
    logic [DATA-1:0]      ram_a_data_in;
    logic [DATA-1:0]      ram_a_data_out;

    always #5 clk = ~clk;

    bank_port_a_arbiter #(.DATA(DATA), .NREQ(NREQ), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .ram_a_w(ram_a_w), .ram_a_adbus(ram_a_adbus), .ram_a_data_in(ram_a_data_in),
        .ram_a_data_out(ram_a_data_out)
    );

    // Synchronous RAM port A with RD_LAT cycles from address to data.
    logic [DATA-1:0] ram [16];
    logic [DATA-1:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        if (ram_a_w) ram[ram_a_adbus] <= ram_a_data_in;
        rd_pipe[0] <= ram[ram_a_adbus];
        for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign ram_a_data_out = rd_pipe[RD_LAT-1];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [DATA-1:0] act, input logic [DATA-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Timing-level view: the arbiter is free again at cycle free_at; an
    // acceptance at cycle c schedules a port access at c+1 and, for reads,
    // a response at c+2+RD_LAT carrying the memory contents in acceptance order.
    typedef struct { int cyc; bit we; logic [3:0] a; logic [DATA-1:0] d; } iss_t;
    typedef struct { int cyc; int own; logic [DATA-1:0] d; } rsp_t;
    iss_t iq[$];
    rsp_t rq[$];
    logic [DATA-1:0] ref_mem [16];
    int  cyc = 0;
    int  free_at = 0;
    int  ptr_m = 0;
    bit  started = 0;
    bit  after_rst = 0;

    // Observation logs used by the directed literal checks.
    int              glog[$];
    int              gcyc[$];
    int              wcnt = 0;
    int              rsp_cnt = 0;
    logic [NREQ-1:0] last_rsp_vec = '0;
    logic [DATA-1:0] last_dat = '0;
    int              last_rsp_cyc = 0;

    always @(negedge clk) begin : compare
        logic [NREQ-1:0] exp_ready;
        logic [NREQ-1:0] exp_rsp;
        bit              idle;
        int              w;
        int              j;
        if (!rst_n) begin
            started   = 1;
            after_rst = 1;
            ptr_m     = 0;
            free_at   = cyc + 1;
            iq.delete();
            rq.delete();
        end else if (started) begin
            if (after_rst) begin
                check("rst_adbus", ram_a_adbus, '0);
                check("rst_rdata", rsp_rdata, '0);
                after_rst = 0;
            end
            idle      = (cyc >= free_at);
            exp_ready = '0;
            if (idle && req_valid != '0) begin
                w = -1;
                for (int k = 0; k < NREQ; k++) begin
                    j = (ptr_m + k) % NREQ;
                    if (w < 0 && req_valid[j]) w = j;
                end
                exp_ready[w] = 1'b1;
                ptr_m = (w + 1) % NREQ;
                iq.push_back('{cyc + 1, req_we[w], req_addr[4*w +: 4], req_wdata[DATA*w +: DATA]});
                if (req_we[w]) begin
                    ref_mem[req_addr[4*w +: 4]] = req_wdata[DATA*w +: DATA];
                    free_at = cyc + 2;
                end else begin
                    rq.push_back('{cyc + 2 + RD_LAT, w, ref_mem[req_addr[4*w +: 4]]});
                    free_at = cyc + 3 + RD_LAT;
                end
            end
            check("req_ready", req_ready, exp_ready);
            check("busy", busy, !idle);
            if (iq.size() > 0 && iq[0].cyc == cyc) begin
                check("ram_a_w", ram_a_w, iq[0].we);
                check("ram_a_adbus", ram_a_adbus, iq[0].a);
                check("ram_a_data_in", ram_a_data_in, iq[0].d);
                void'(iq.pop_front());
            end else begin
                check("ram_a_w_idle", ram_a_w, 1'b0);
                check("ram_a_data_in_idle", ram_a_data_in, '0);
            end
            exp_rsp = '0;
            if (rq.size() > 0 && rq[0].cyc == cyc) begin
                exp_rsp[rq[0].own] = 1'b1;
                check("rsp_rdata", rsp_rdata, rq[0].d);
                void'(rq.pop_front());
            end
            check("rsp_valid", rsp_valid, exp_rsp);

            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) begin
                    glog.push_back(i);
                    gcyc.push_back(cyc);
                end
            end
            if (rsp_valid != '0) begin
                rsp_cnt++;
                last_rsp_vec = rsp_valid;
                last_dat     = rsp_rdata;
                last_rsp_cyc = cyc;
            end
            if (ram_a_w) wcnt++;
        end
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        wait_cyc(1);
        rst_n = 1'b1;
    endtask

    // Single-shot request: hold fields until accepted, then drop valid.
    // Returns just after the edge that ends the acceptance cycle.
    task automatic do_op(input int i, input bit we, input logic [3:0] a, input logic [DATA-1:0] d);
        int n;
        req_we[i]               = we;
        req_addr[4*i +: 4]      = a;
        req_wdata[DATA*i +: DATA] = d;
        req_valid[i]            = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready[i]) break;
            n++;
            if (n >= 100) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout req=%0d: got no req_ready expected accept within 100 cycles", i);
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    function automatic int count_of(input int v);
        int c = 0;
        foreach (glog[k]) if (glog[k] == v) c++;
        return c;
    endfunction

    logic [3:0]      t4_addr [4];
    logic [DATA-1:0] t4_data;
    int              w0;
    int              n0;

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(1);

        // 1: write then read-back through a different requester
        glog.delete(); gcyc.delete();
        w0 = wcnt;
        do_op(0, 1'b1, 4'h5, {8{32'hA5A5_0001}});
        do_op(1, 1'b0, 4'h5, '0);
        wait_cyc(5);
        check("t1_write_cycles", wcnt - w0, 1);
        check("t1_grants", glog.size(), 2);
        check("t1_rsp_vec", last_rsp_vec, 3'b010);
        check("t1_rsp_data", last_dat, {8{32'hA5A5_0001}});
        check("t1_latency", last_rsp_cyc - gcyc[1], 3);

        // 2: all three read continuously
        rst_pulse();
        glog.delete(); gcyc.delete();
        req_we   = '0;
        req_addr = {4'h5, 4'h5, 4'h5};
        req_valid = '1;
        wait_cyc(24);
        req_valid = '0;
        wait_cyc(8);
        check("t2_grants", glog.size(), 6);
        for (int k = 0; k < 6; k++) check("t2_order", glog[k], k % 3);
        for (int k = 1; k < 6; k++) check("t2_spacing", gcyc[k] - gcyc[k-1], 4);

        // 3: req0 and req2 held, req1 idle
        rst_pulse();
        glog.delete(); gcyc.delete();
        req_valid = 3'b101;
        wait_cyc(16);
        req_valid = '0;
        wait_cyc(8);
        check("t3_grants", glog.size(), 4);
        check("t3_g0", glog[0], 0);
        check("t3_g1", glog[1], 2);
        check("t3_g2", glog[2], 0);
        check("t3_g3", glog[3], 2);
        check("t3_req1_never", count_of(1), 0);

        // 4: one word in each bank, written then read back
        t4_addr = '{4'h0, 4'h7, 4'hB, 4'hF};
        for (int k = 0; k < 4; k++) begin
            t4_data = {8{32'hC0DE_0000 + 32'(k)}};
            do_op(k % 3, 1'b1, t4_addr[k], t4_data);
        end
        for (int k = 0; k < 4; k++) begin
            do_op((k + 1) % 3, 1'b0, t4_addr[k], '0);
            wait_cyc(4);
            t4_data = {8{32'hC0DE_0000 + 32'(k)}};
            check("t4_readback", last_dat, t4_data);
        end

        // 5: reset while a req2 read is in WAIT
        rst_pulse();
        n0 = rsp_cnt;
        do_op(2, 1'b0, 4'h7, '0);
        wait_cyc(1);
        rst_pulse();
        wait_cyc(6);
        check("t5_no_rsp", rsp_cnt - n0, 0);
        glog.delete(); gcyc.delete();
        req_we    = '0;
        req_valid = '1;
        wait_cyc(2);
        req_valid = '0;
        wait_cyc(6);
        check("t5_grants", glog.size(), 1);
        check("t5_first_grant", glog[0], 0);

        // 6: req1 withdraws while the sequencer is busy
        glog.delete(); gcyc.delete();
        w0 = wcnt;
        do_op(0, 1'b0, 4'hB, '0);
        req_we[1]              = 1'b1;
        req_addr[4 +: 4]       = 4'h3;
        req_wdata[DATA +: DATA] = {8{32'hDEAD_BEEF}};
        req_valid[1]           = 1'b1;
        wait_cyc(1);
        req_valid[1] = 1'b0;
        wait_cyc(6);
        check("t6_req1_never", count_of(1), 0);
        check("t6_no_write", wcnt - w0, 0);

        check("model_issue_drained", iq.size(), 0);
        check("model_rsp_drained", rq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
